// File: rtl/s5_counter_pkg.sv
// Shared types and decode constants for the modulo up/down counter.
package s5_counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest counter the lab datapaths instantiate; value carries one guard bit.
    localparam int CNT_MAX_W = 64;

    typedef struct packed {
        logic [CNT_MAX_W:0] value;
        logic               tc;
    } step_result_t;

endpackage

// File: rtl/s5_step_alu.sv
// Combinational next-value / terminal-count logic for one counter step.
module s5_step_alu
    import s5_counter_pkg::*;
#(
    parameter int N = 64,
    parameter int S = 8
) (
    input  logic [N:0]   i_count,
    input  logic [N-1:0] i_limit,
    input  logic [S-1:0] i_step,
    input  logic         i_dec,
    input  cnt_mode_e    i_mode,
    output logic [N:0]   o_value,
    output logic         o_tc
);

    logic [N:0] w_limx;
    logic [N:0] w_lim1;
    logic [N:0] w_stepx;
    logic [N:0] w_st;
    logic [N:0] w_sum;
    logic [N:0] w_diff;

    assign w_limx  = {1'b0, i_limit};
    assign w_lim1  = w_limx + 1'b1;
    assign w_stepx = {{(N + 1 - S){1'b0}}, i_step};
    // A step larger than the whole range behaves like one full revolution.
    assign w_st    = (w_stepx < w_lim1) ? w_stepx : w_lim1;
    assign w_sum   = i_count + w_st;
    assign w_diff  = i_count - w_st;

    always_comb begin
        o_value = i_count;
        o_tc    = 1'b0;
        if (i_dec == DIR_UP) begin
            if (w_sum <= w_limx) begin
                o_value = w_sum;
            end else begin
                o_tc    = 1'b1;
                o_value = (i_mode == MODE_WRAP) ? (w_sum - w_lim1) : w_limx;
            end
        end else begin
            if (w_st <= i_count) begin
                o_value = w_diff;
            end else begin
                o_tc    = 1'b1;
                o_value = (i_mode == MODE_WRAP) ? (w_diff + w_lim1) : '0;
            end
        end
    end

endmodule

// File: rtl/s5_counter_mod_updown.sv
// Modulo up/down counter with programmable step, wrap/saturate and sticky overflow.
module s5_counter_mod_updown
    import s5_counter_pkg::*;
#(
    parameter int           N           = 64,
    parameter int           S           = 8,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [N-1:0] i_load_value,
    input  logic         i_enable,
    input  logic         i_dec,
    input  logic [S-1:0] i_step,
    input  logic [N-1:0] i_limit,
    input  logic         i_sat_mode,
    input  logic         i_clear_ovf,
    output logic [N-1:0] o_counterN,
    output logic         o_tc,
    output logic         o_ovf_sticky,
    output logic         o_at_max,
    output logic         o_at_zero
);

    // Guard bit kept so comparisons against limit share one width.
    logic [N:0] r_count;
    logic       r_tc;
    logic       r_ovf;

    logic [N:0] w_limx;
    logic [N:0] w_ldx;
    logic [N:0] w_alu_value;
    logic       w_alu_tc;
    logic [N:0] w_next;
    logic       w_tc_next;
    logic       w_ovf_next;

    assign w_limx = {1'b0, i_limit};
    assign w_ldx  = {1'b0, i_load_value};

    s5_step_alu #(
        .N (N),
        .S (S)
    ) u_alu (
        .i_count (r_count),
        .i_limit (i_limit),
        .i_step  (i_step),
        .i_dec   (i_dec),
        .i_mode  (cnt_mode_e'(i_sat_mode)),
        .o_value (w_alu_value),
        .o_tc    (w_alu_tc)
    );

    always_comb begin
        w_next    = r_count;
        w_tc_next = 1'b0;
        if (i_load) begin
            w_next = (w_ldx > w_limx) ? w_limx : w_ldx;
        end else if (r_count > w_limx) begin
            w_next = w_limx;
        end else if (i_enable) begin
            w_next    = w_alu_value;
            w_tc_next = w_alu_tc;
        end
        w_ovf_next = w_tc_next ? 1'b1 : (i_clear_ovf ? 1'b0 : r_ovf);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= {1'b0, RESET_VALUE};
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_tc_next;
            r_ovf   <= w_ovf_next;
        end
    end

    assign o_counterN   = r_count[N-1:0];
    assign o_tc         = r_tc;
    assign o_ovf_sticky = r_ovf;
    assign o_at_max     = (r_count == w_limx);
    assign o_at_zero    = (r_count == '0);

endmodule

// File: tb/tb_s5_counter_mod_updown.sv
// Scoreboard bench: directed vectors push expectations, a monitor pops after each edge.
module tb_s5_counter_mod_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_load, a_enable, a_dec, a_sat, a_clr;
    logic [7:0]  a_lv, a_limit, a_cnt;
    logic [3:0]  a_step;
    logic        a_tc, a_ovf, a_max, a_zero;

    logic        b_reset, b_load, b_enable, b_dec, b_sat, b_clr;
    logic [63:0] b_lv, b_limit, b_cnt;
    logic [7:0]  b_step;
    logic        b_tc, b_ovf, b_max, b_zero;

    s5_counter_mod_updown #(.N(8), .S(4)) dut_a (
        .i_clock(clk), .i_reset(a_reset), .i_load(a_load),
        .i_load_value(a_lv), .i_enable(a_enable), .i_dec(a_dec),
        .i_step(a_step), .i_limit(a_limit), .i_sat_mode(a_sat),
        .i_clear_ovf(a_clr), .o_counterN(a_cnt), .o_tc(a_tc),
        .o_ovf_sticky(a_ovf), .o_at_max(a_max), .o_at_zero(a_zero)
    );

    s5_counter_mod_updown #(.N(64), .S(8)) dut_b (
        .i_clock(clk), .i_reset(b_reset), .i_load(b_load),
        .i_load_value(b_lv), .i_enable(b_enable), .i_dec(b_dec),
        .i_step(b_step), .i_limit(b_limit), .i_sat_mode(b_sat),
        .i_clear_ovf(b_clr), .o_counterN(b_cnt), .o_tc(b_tc),
        .o_ovf_sticky(b_ovf), .o_at_max(b_max), .o_at_zero(b_zero)
    );

    typedef struct {
        int          dut;
        logic [63:0] cnt;
        logic        tc;
        logic        ovf;
        logic [63:0] lim;
        string       nm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic [63:0] c;
        logic t, o, mx, z;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.dut == 0) begin
                c = {56'b0, a_cnt}; t = a_tc; o = a_ovf; mx = a_max; z = a_zero;
            end else begin
                c = b_cnt; t = b_tc; o = b_ovf; mx = b_max; z = b_zero;
            end
            chk(e.nm, "cnt", c, e.cnt);
            chk(e.nm, "tc", {63'b0, t}, {63'b0, e.tc});
            chk(e.nm, "ovf", {63'b0, o}, {63'b0, e.ovf});
            chk(e.nm, "at_max", {63'b0, mx}, {63'b0, e.cnt == e.lim});
            chk(e.nm, "at_zero", {63'b0, z}, {63'b0, e.cnt == 64'd0});
        end
    end

    task automatic cyc_a(input logic rst, ld, input logic [7:0] lv,
                         input logic en, dc, input logic [3:0] st,
                         input logic [7:0] lim, input logic sat, clr,
                         input logic [7:0] ec, input logic etc, eovf,
                         input string nm);
        exp_t e;
        a_reset = rst; a_load = ld; a_lv = lv; a_enable = en; a_dec = dc;
        a_step = st; a_limit = lim; a_sat = sat; a_clr = clr;
        e.dut = 0; e.cnt = {56'b0, ec}; e.tc = etc; e.ovf = eovf;
        e.lim = {56'b0, lim}; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    task automatic cyc_b(input logic rst, ld, input logic [63:0] lv,
                         input logic en, input logic [7:0] st,
                         input logic [63:0] lim,
                         input logic [63:0] ec, input logic etc, eovf,
                         input string nm);
        exp_t e;
        b_reset = rst; b_load = ld; b_lv = lv; b_enable = en; b_dec = 1'b0;
        b_step = st; b_limit = lim; b_sat = 1'b0; b_clr = 1'b0;
        e.dut = 1; e.cnt = ec; e.tc = etc; e.ovf = eovf;
        e.lim = lim; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;

    initial begin
        b_reset = 1'b1; b_load = 1'b0; b_lv = '0; b_enable = 1'b0;
        b_dec = 1'b0; b_step = '0; b_limit = ALL1; b_sat = 1'b0; b_clr = 1'b0;
        #1;
        // reset dominates load/enable
        for (int i = 0; i < 3; i++)
            cyc_a(1, 1, 8'd5, 1, 0, 4'd1, 8'd9, 0, 0, 8'd0, 0, 0, "rst");
        // up wrap, limit 9
        cyc_a(0, 1, 8'd8, 0, 0, 4'd1, 8'd9, 0, 0, 8'd8, 0, 0, "t2_ld");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd1, 8'd9, 0, 0, 8'd9, 0, 0, "t2_9");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd1, 8'd9, 0, 0, 8'd0, 1, 1, "t2_wrap");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd1, 8'd9, 0, 0, 8'd1, 0, 1, "t2_1");
        // up saturate, limit 200
        cyc_a(0, 1, 8'd195, 0, 0, 4'd7, 8'd200, 1, 0, 8'd195, 0, 1, "t3_ld");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd7, 8'd200, 1, 0, 8'd200, 1, 1, "t3_sat");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd7, 8'd200, 1, 0, 8'd200, 1, 1, "t3_sat2");
        cyc_a(0, 0, 8'd0, 0, 0, 4'd7, 8'd200, 1, 1, 8'd200, 0, 0, "t3_clr");
        // down wrap, step 3
        cyc_a(0, 1, 8'd1, 0, 1, 4'd3, 8'd9, 0, 0, 8'd1, 0, 0, "t4_ld");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0, 0, 8'd8, 1, 1, "t4_8");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0, 0, 8'd5, 0, 1, "t4_5");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0, 0, 8'd2, 0, 1, "t4_2");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd3, 8'd9, 0, 0, 8'd9, 1, 1, "t4_9");
        cyc_a(0, 0, 8'd0, 0, 1, 4'd3, 8'd9, 0, 1, 8'd9, 0, 0, "t4_clr");
        // load beats enable and is clipped to limit; set beats clear
        cyc_a(0, 1, 8'd50, 1, 0, 4'd1, 8'd20, 0, 0, 8'd20, 0, 0, "t5_ld");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd1, 8'd20, 0, 1, 8'd0, 1, 1, "t5_setclr");
        // limit lowered below count, then reset mid-count
        cyc_a(0, 1, 8'd15, 0, 0, 4'd2, 8'd20, 0, 0, 8'd15, 0, 1, "t6_ld");
        cyc_a(0, 0, 8'd0, 0, 0, 4'd2, 8'd10, 0, 0, 8'd10, 0, 1, "t6_clamp");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd2, 8'd10, 0, 0, 8'd1, 1, 1, "t6_wrap");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd2, 8'd10, 0, 0, 8'd3, 0, 1, "t6_3");
        cyc_a(1, 0, 8'd0, 1, 0, 4'd2, 8'd10, 0, 0, 8'd0, 0, 0, "t6_rst");
        // step 0, full-range step, down saturate
        cyc_a(0, 1, 8'd4, 0, 0, 4'd0, 8'd9, 0, 0, 8'd4, 0, 0, "x_ld");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd0, 8'd9, 0, 0, 8'd4, 0, 0, "x_step0");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd10, 8'd9, 0, 0, 8'd4, 1, 1, "x_full_up");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd15, 8'd9, 0, 0, 8'd4, 1, 1, "x_full_dn");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd5, 8'd9, 1, 0, 8'd0, 1, 1, "x_sat_dn");
        cyc_a(0, 0, 8'd0, 1, 1, 4'd5, 8'd9, 1, 0, 8'd0, 1, 1, "x_sat_dn2");
        // limit 0 pins the counter
        cyc_a(0, 1, 8'd7, 0, 0, 4'd5, 8'd0, 0, 1, 8'd0, 0, 0, "z_ld");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd5, 8'd0, 0, 0, 8'd0, 1, 1, "z_up");
        cyc_a(0, 0, 8'd0, 1, 0, 4'd0, 8'd0, 0, 0, 8'd0, 0, 1, "z_step0");
        cyc_a(0, 0, 8'd0, 0, 0, 4'd0, 8'd9, 0, 0, 8'd0, 0, 1, "idle");
        // 64-bit full-range wrap
        cyc_b(1, 0, 64'd0, 0, 8'd15, ALL1, 64'd0, 0, 0, "w_rst");
        cyc_b(0, 1, M2, 0, 8'd15, ALL1, M2, 0, 0, "w_ld");
        cyc_b(0, 0, 64'd0, 1, 8'd15, ALL1, 64'd13, 1, 1, "w_wrap");
        cyc_b(0, 0, 64'd0, 1, 8'd15, ALL1, 64'd28, 0, 1, "w_28");
        a_enable = 1'b0;
        b_enable = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
